sevseg_reader: RTL and testbench
================================

Name: sevseg_reader

Overview:
- Passive receiver for a multiplexed, active-low seven-segment display bus (anode strobes plus shared segment lines) driven by our segment decoders and scan logic.
- Waits for each strobed digit's pattern to settle, then decodes the segment pattern back to a 4-bit value.
- Assembles one value per digit position and publishes the full frame with a one-cycle valid pulse.
- Used in loopback self-test and to monitor display outputs from a second board.

Parameters:
- NDIG, 4: number of multiplexed digit positions (1..8).
- STABLE_CYC, 16: consecutive cycles a registered (AN, SEG) pair must stay unchanged before a digit is captured (≥2).
- AN_ACTIVE_LOW, 1: 1 means an anode bit is active at 0; 0 means active at 1.

Ports:
- CLK  in  1  system clock; all logic on the rising edge.
- RST  in  1  synchronous, active-high reset.
- AN  in  NDIG  anode strobes; bit i selects digit position i.
- SEG  in  8  segment lines, active low; bit7=a, bit6=b … bit1=g, bit0=dp.
- DIGITS  out  4*NDIG  decoded values; DIGITS[4i+3:4i] is position i.
- BLANK  out  NDIG  1 = position showed the all-off pattern.
- DP  out  NDIG  1 = decimal point lit (SEG[0]==0) at capture.
- ERR  out  NDIG  1 = position showed an unrecognised pattern.
- VALID  out  1  one-cycle pulse: DIGITS/BLANK/DP/ERR updated with a new frame.

Behaviour:
- Input stage: AN and SEG are registered once (r_an, r_seg). All decisions use the registered values.
- Active-level normalisation: when AN_ACTIVE_LOW=1, r_an is inverted internally so that 1 always means active.
- Anode qualification: a cycle is "qualified" only when the normalised r_an is one-hot. Zero or multiple active bits force state IDLE and clear the settle counter.
- Decode, on r_seg[7:1], dp ignored:
  - 0000001→0, 1001111→1, 0010010→2, 0000110→3, 1001100→4, 0100100→5, 0100000→6, 0001111→7, 0000000→8, 0000100→9.
  - 1111111 → value 4'hF with BLANK.
  - Anything else → value 4'hE with ERR.
  - BLANK and ERR are mutually exclusive.
- FSM states:
  - IDLE: on a qualified cycle, load cnt=0 and go to SETTLE.
  - SETTLE: if r_an and r_seg equal the previous cycle's values and the cycle is still qualified, cnt increments. If either changed, cnt=0 and stay in SETTLE. On an unqualified cycle, go to IDLE.
  - Capture (SETTLE→CAPTURED): when cnt reaches STABLE_CYC-1, capture slot i (index of the active bit) into the shadow registers, set seen[i], go to CAPTURED.
  - CAPTURED: hold. Any change of r_an or r_seg returns to SETTLE with cnt=0; an unqualified cycle goes to IDLE. No second capture occurs within one activation.
- Capture timing: a port pair held constant for STABLE_CYC+1 cycles is guaranteed to be captured. A pair held for STABLE_CYC-1 cycles or fewer is never captured.
- Recapture: a slot captured again before its frame completes is overwritten with the newer value.
- Frame completion: on the cycle after seen becomes all-ones:
  - DIGITS/BLANK/DP/ERR load from the shadow registers.
  - VALID=1 for exactly one cycle.
  - seen clears.
  - Outputs otherwise hold their last frame.
- Simultaneous events: if the completing capture and a new capture of some slot fall on consecutive cycles, the frame publishes the shadow as it stood at completion. The new capture counts toward the next frame.
- cnt width: clog2(STABLE_CYC); it never wraps because it is compared and then stopped.
- Reset values (RST high on an edge, including mid-frame): DIGITS=0, BLANK=all 1, DP=0, ERR=0, VALID=0, seen=0, cnt=0, state IDLE, shadow cleared, r_an=inactive, r_seg=8'hFF. Partial frames are discarded.

Test Plan:
- NDIG=4, STABLE_CYC=4, AN_ACTIVE_LOW=1. Scan AN=1110,1101,1011,0111 with SEG=0x9F,0x25,0x0D,0x99, 10 cycles each → one VALID pulse; DIGITS=16'h4321, BLANK=0, ERR=0, DP=0.
- Same scan, but position 2 toggles SEG between 0x0D and 0x49 every 2 cycles → position 2 never captured, no VALID. Then hold 0x49 for 6 cycles and complete the scan → DIGITS[11:8]=5.
- Position 0 shows 0xFF, position 1 shows 0x00 (8 with dp), position 2 shows 0x7F (invalid) → BLANK=0001, DP=0010, ERR=0100, DIGITS[3:0]=F, [11:8]=E.
- AN=1100 (two active) held 20 cycles → no capture. AN=1111 → no capture. seen and state stay IDLE.
- Assert RST one cycle after slots 0–2 captured, then complete one full scan → exactly one VALID, and only after all four slots are recaptured post-reset. Outputs read reset values until then.
- Continuous scan for 5 frames with changing values → exactly 5 VALID pulses, each one cycle wide; each frame matches the values driven.

Source files
------------

// File: rtl/sevseg_reader.sv
// -----------------------------------------------------------------------------
// sevseg_reader
// Passive receiver for a multiplexed, active-low seven-segment display bus.
// Each strobed digit is allowed to settle, its segment pattern is decoded back
// to a 4-bit value, and once every digit position has been captured the whole
// frame is published together with a one-cycle VALID pulse.
//
// Ports
//   CLK     in   system clock, rising edge
//   RST     in   synchronous active-high reset
//   AN      in   [NDIG]    anode strobes, bit i selects position i
//   SEG     in   [8]       segments, active low: 7=a 6=b .. 1=g 0=dp
//   DIGITS  out  [4*NDIG]  decoded values, DIGITS[4i+3:4i] is position i
//   BLANK   out  [NDIG]    position showed the all-off pattern
//   DP      out  [NDIG]    decimal point was lit at capture
//   ERR     out  [NDIG]    position showed an unrecognised pattern
//   VALID   out  1         one-cycle pulse: outputs updated with a new frame
// -----------------------------------------------------------------------------
module sevseg_reader #(
    parameter int NDIG          = 4,
    parameter int STABLE_CYC    = 16,
    parameter bit AN_ACTIVE_LOW = 1'b1
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [NDIG-1:0]     AN,
    input  logic [7:0]          SEG,
    output logic [4*NDIG-1:0]   DIGITS,
    output logic [NDIG-1:0]     BLANK,
    output logic [NDIG-1:0]     DP,
    output logic [NDIG-1:0]     ERR,
    output logic                VALID
);

    localparam int CW = (STABLE_CYC > 2) ? $clog2(STABLE_CYC) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(STABLE_CYC - 1);
    // Register value meaning "no anode active" in the bus's own polarity
    localparam logic [NDIG-1:0] AN_IDLE  = AN_ACTIVE_LOW ? {NDIG{1'b1}} : {NDIG{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SETTLE   = 2'd1,
        ST_CAPTURED = 2'd2
    } state_t;

    // Pattern lookup on segments a..g (dp excluded). Result is {err, blank, value}.
    function automatic logic [5:0] decode_seg(input logic [6:0] pat);
        case (pat)
            7'b0000001: decode_seg = {2'b00, 4'h0};
            7'b1001111: decode_seg = {2'b00, 4'h1};
            7'b0010010: decode_seg = {2'b00, 4'h2};
            7'b0000110: decode_seg = {2'b00, 4'h3};
            7'b1001100: decode_seg = {2'b00, 4'h4};
            7'b0100100: decode_seg = {2'b00, 4'h5};
            7'b0100000: decode_seg = {2'b00, 4'h6};
            7'b0001111: decode_seg = {2'b00, 4'h7};
            7'b0000000: decode_seg = {2'b00, 4'h8};
            7'b0000100: decode_seg = {2'b00, 4'h9};
            7'b1111111: decode_seg = {2'b01, 4'hF};
            default:    decode_seg = {2'b10, 4'hE};
        endcase
    endfunction

    logic [NDIG-1:0]    an_r;
    logic [7:0]         seg_r;
    logic [NDIG-1:0]    an_prev_r;
    logic [7:0]         seg_prev_r;
    logic [NDIG-1:0]    an_act_s;
    logic               qual_s;
    logic               same_s;
    logic [5:0]         dec_s;

    state_t             state_r;
    state_t             state_s;
    logic [CW-1:0]      cnt_r;
    logic [CW-1:0]      cnt_s;
    logic               cap_s;

    logic [NDIG-1:0]    seen_r;
    logic               frame_done_s;
    logic [4*NDIG-1:0]  shadow_val_r;
    logic [NDIG-1:0]    shadow_blank_r;
    logic [NDIG-1:0]    shadow_dp_r;
    logic [NDIG-1:0]    shadow_err_r;

    logic [4*NDIG-1:0]  digits_r;
    logic [NDIG-1:0]    blank_r;
    logic [NDIG-1:0]    dp_r;
    logic [NDIG-1:0]    err_r;
    logic               valid_r;

    // Input stage plus a one-cycle history used for the "unchanged" test
    always_ff @(posedge CLK) begin
        if (RST) begin
            an_r       <= AN_IDLE;
            seg_r      <= 8'hFF;
            an_prev_r  <= AN_IDLE;
            seg_prev_r <= 8'hFF;
        end else begin
            an_r       <= AN;
            seg_r      <= SEG;
            an_prev_r  <= an_r;
            seg_prev_r <= seg_r;
        end
    end

    // Normalise anode polarity, qualify on exactly one active anode, decode segments
    always_comb begin
        an_act_s = an_r;
        if (AN_ACTIVE_LOW) begin
            an_act_s = ~an_r;
        end else begin
            an_act_s = an_r;
        end
        // x & (x-1) clears the lowest set bit, so it is zero only for 0 or one-hot
        qual_s       = (an_act_s != {NDIG{1'b0}}) &&
                       ((an_act_s & (an_act_s - NDIG'(1))) == {NDIG{1'b0}});
        same_s       = (an_r == an_prev_r) && (seg_r == seg_prev_r);
        dec_s        = decode_seg(seg_r[7:1]);
        frame_done_s = &seen_r;
    end

    // Settle FSM state and counter register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CW{1'b0}};
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
        end
    end

    // Settle FSM next-state: count unchanged qualified cycles, capture once per activation
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        cap_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                cnt_s = {CW{1'b0}};
                if (qual_s) begin
                    state_s = ST_SETTLE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (!qual_s) begin
                    state_s = ST_IDLE;
                    cnt_s   = {CW{1'b0}};
                end else if (!same_s) begin
                    cnt_s   = {CW{1'b0}};
                end else if (cnt_r == CNT_LAST) begin
                    // Counter stops here, so it never wraps
                    cap_s   = 1'b1;
                    state_s = ST_CAPTURED;
                end else begin
                    cnt_s   = cnt_r + CW'(1);
                end
            end
            ST_CAPTURED: begin
                if (!qual_s) begin
                    state_s = ST_IDLE;
                    cnt_s   = {CW{1'b0}};
                end else if (!same_s) begin
                    state_s = ST_SETTLE;
                    cnt_s   = {CW{1'b0}};
                end else begin
                    state_s = ST_CAPTURED;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = {CW{1'b0}};
            end
        endcase
    end

    // Shadow frame and seen mask; a completing frame clears seen but a capture
    // landing on the publish cycle still counts toward the next frame
    always_ff @(posedge CLK) begin
        if (RST) begin
            seen_r         <= {NDIG{1'b0}};
            shadow_val_r   <= {(4*NDIG){1'b0}};
            shadow_blank_r <= {NDIG{1'b0}};
            shadow_dp_r    <= {NDIG{1'b0}};
            shadow_err_r   <= {NDIG{1'b0}};
        end else begin
            seen_r <= (frame_done_s ? {NDIG{1'b0}} : seen_r) |
                      (cap_s ? an_act_s : {NDIG{1'b0}});
            for (int k = 0; k < NDIG; k++) begin
                if (cap_s && an_act_s[k]) begin
                    shadow_val_r[4*k +: 4] <= dec_s[3:0];
                    shadow_blank_r[k]      <= dec_s[4];
                    shadow_err_r[k]        <= dec_s[5];
                    shadow_dp_r[k]         <= ~seg_r[0];
                end
            end
        end
    end

    // Published frame: loads from the shadow the cycle after seen fills, else holds
    always_ff @(posedge CLK) begin
        if (RST) begin
            digits_r <= {(4*NDIG){1'b0}};
            blank_r  <= {NDIG{1'b1}};
            dp_r     <= {NDIG{1'b0}};
            err_r    <= {NDIG{1'b0}};
            valid_r  <= 1'b0;
        end else begin
            valid_r <= frame_done_s;
            if (frame_done_s) begin
                digits_r <= shadow_val_r;
                blank_r  <= shadow_blank_r;
                dp_r     <= shadow_dp_r;
                err_r    <= shadow_err_r;
            end
        end
    end

    assign DIGITS = digits_r;
    assign BLANK  = blank_r;
    assign DP     = dp_r;
    assign ERR    = err_r;
    assign VALID  = valid_r;

endmodule

// File: tb/tb_sevseg_reader.sv
// -----------------------------------------------------------------------------
// tb_sevseg_reader
// Self-checking bench for sevseg_reader (NDIG=4, STABLE_CYC=4, active-low AN).
// Full scans come from a vector table; each scan pushes its expected frame to a
// scoreboard queue that a VALID monitor pops and compares. Hand-written
// sequences cover settle boundaries, multi-active anodes and mid-frame reset.
// -----------------------------------------------------------------------------
module tb_sevseg_reader;

    localparam int NDIG = 4;

    logic                CLK;
    logic                RST;
    logic [NDIG-1:0]     AN;
    logic [7:0]          SEG;
    logic [4*NDIG-1:0]   DIGITS;
    logic [NDIG-1:0]     BLANK;
    logic [NDIG-1:0]     DP;
    logic [NDIG-1:0]     ERR;
    logic                VALID;

    sevseg_reader #(
        .NDIG          (NDIG),
        .STABLE_CYC    (4),
        .AN_ACTIVE_LOW (1'b1)
    ) dut (
        .CLK    (CLK),
        .RST    (RST),
        .AN     (AN),
        .SEG    (SEG),
        .DIGITS (DIGITS),
        .BLANK  (BLANK),
        .DP     (DP),
        .ERR    (ERR),
        .VALID  (VALID)
    );

    typedef struct packed {
        logic [15:0] digits;
        logic [3:0]  blank;
        logic [3:0]  dp;
        logic [3:0]  err;
    } frame_t;

    // seg holds {pos3, pos2, pos1, pos0}
    typedef struct {
        logic [31:0] seg;
        int          hold;
        frame_t      exp;
    } vec_t;

    frame_t sb[$];
    vec_t   vecs[6];
    int     n_vec   = 0;
    int     n_err   = 0;
    int     n_valid = 0;
    logic   valid_prev = 1'b0;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every VALID pops one expected frame
    always @(negedge CLK) begin
        frame_t fr;
        if (!RST && VALID) begin
            n_valid++;
            check("valid_width", 32'(valid_prev), 32'd0);
            check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                fr = sb.pop_front();
                check("digits", 32'(DIGITS), 32'(fr.digits));
                check("blank",  32'(BLANK),  32'(fr.blank));
                check("dp",     32'(DP),     32'(fr.dp));
                check("err",    32'(ERR),    32'(fr.err));
            end
        end
        valid_prev <= VALID;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic show(input int pos, input logic [7:0] seg, input int cyc);
        AN  = ~(4'b0001 << pos);
        SEG = seg;
        repeat (cyc) @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int cyc);
        AN  = 4'hF;
        SEG = 8'hFF;
        repeat (cyc) @(posedge CLK);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        @(negedge CLK);
        check({tag, "_digits"}, 32'(DIGITS), 32'h0);
        check({tag, "_blank"},  32'(BLANK),  32'hF);
        check({tag, "_dp"},     32'(DP),     32'h0);
        check({tag, "_err"},    32'(ERR),    32'h0);
        check({tag, "_valid"},  32'(VALID),  32'h0);
        @(posedge CLK);
        #1;
    endtask

    initial begin
        int base;
        vecs[0] = '{32'h990D259F, 10, '{16'h4321, 4'b0000, 4'b0000, 4'b0000}};
        vecs[1] = '{32'h9F7F00FF, 6,  '{16'h1E8F, 4'b0001, 4'b0010, 4'b0100}};
        vecs[2] = '{32'h091F4103, 6,  '{16'h9760, 4'b0000, 4'b0000, 4'b0000}};
        vecs[3] = '{32'h02FE4801, 6,  '{16'h0F58, 4'b0100, 4'b1110, 4'b0000}};
        vecs[4] = '{32'h55980C9E, 6,  '{16'hE431, 4'b0000, 4'b0111, 4'b1000}};
        vecs[5] = '{32'h1F030901, 5,  '{16'h7098, 4'b0000, 4'b0000, 4'b0000}};

        RST = 1'b1;
        AN  = 4'hF;
        SEG = 8'hFF;
        repeat (3) @(posedge CLK);
        #1;
        check_reset_outputs("reset");
        RST = 1'b0;
        idle(4);

        // Back-to-back scans from the table; last one holds exactly STABLE_CYC+1
        base = n_valid;
        for (int v = 0; v < 6; v++) begin
            sb.push_back(vecs[v].exp);
            for (int p = 0; p < NDIG; p++) begin
                show(p, vecs[v].seg[p*8 +: 8], vecs[v].hold);
            end
        end
        idle(20);
        check("table_frames", 32'(n_valid - base), 32'd6);
        check("table_sb_empty", 32'(sb.size()), 32'd0);

        // Multiple or no active anodes never qualify
        base = n_valid;
        show(0, 8'h9F, 1);
        AN = 4'b1100; SEG = 8'h9F; repeat (20) @(posedge CLK); #1;
        AN = 4'b0000; repeat (20) @(posedge CLK); #1;
        AN = 4'b1111; repeat (20) @(posedge CLK); #1;
        @(negedge CLK);
        check("multi_seen", 32'(dut.seen_r), 32'h0);
        check("multi_no_valid", 32'(n_valid - base), 32'd0);
        check("multi_hold_digits", 32'(DIGITS), 32'(vecs[5].exp.digits));
        @(posedge CLK); #1;

        // Position 2 toggles faster than it can settle (2 and 3 cycle holds)
        base = n_valid;
        show(0, 8'h9F, 10);
        show(1, 8'h25, 10);
        for (int i = 0; i < 6; i++) begin
            show(2, (i % 2 == 1) ? 8'h49 : 8'h0D, (i < 4) ? 2 : 3);
        end
        show(3, 8'h99, 10);
        idle(10);
        @(negedge CLK);
        check("toggle_seen", 32'(dut.seen_r), 32'b1011);
        check("toggle_no_valid", 32'(n_valid - base), 32'd0);
        @(posedge CLK); #1;
        sb.push_back('{16'h4521, 4'b0000, 4'b0000, 4'b0000});
        show(2, 8'h49, 6);
        idle(10);
        check("toggle_frames", 32'(n_valid - base), 32'd1);
        check("toggle_sb_empty", 32'(sb.size()), 32'd0);

        // Reset after three slots captured discards the partial frame
        base = n_valid;
        show(0, 8'h03, 10);
        show(1, 8'h41, 10);
        show(2, 8'h1F, 10);
        AN  = 4'hF;
        SEG = 8'hFF;
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        check_reset_outputs("midrst");
        show(3, 8'h09, 10);
        idle(5);
        check("midrst_no_valid", 32'(n_valid - base), 32'd0);
        check_reset_outputs("midrst_hold");
        sb.push_back('{16'h9631, 4'b0000, 4'b0000, 4'b0000});
        show(0, 8'h9F, 10);
        show(1, 8'h0D, 10);
        show(2, 8'h41, 10);
        idle(10);
        check("midrst_frames", 32'(n_valid - base), 32'd1);
        check("final_sb_empty", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
